// File: rtl/sb_arb_pkg.sv
// rtl/sb_arb_pkg.sv - shared types and helpers for switchboard arbiters
//
// Purpose: arbitration state encoding and a width helper used by the TX
// arbiter and by the round-robin picker.
// Ports: none (package).

package sb_arb_pkg;

  // Arbitration state: UNLOCKED arbitrates every cycle, LOCKED holds the
  // sink for the current owner until it sends a beat with last=1.
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

  // ceil(log2(n)), but never less than 1 so a 1-bit index always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sb_rr_pick.sv
// rtl/sb_rr_pick.sv - combinational round-robin picker
//
// Purpose: grant the first requester after ptr, scanning ptr+1, ptr+2, ...
// modulo N. Built as a double-width masked priority encoder: the request
// vector is duplicated, positions 0..ptr of the lower copy are masked off,
// and the lowest set bit of the 2N-bit vector wins (its index folded mod N).
// Ports:
//   req     in  N   request per port
//   ptr     in  IW  last granted index (scan starts at ptr+1)
//   gnt     out N   one-hot grant, zero when no request
//   gnt_idx out IW  index of the granted port (0 when no request)

module sb_rr_pick import sb_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N; i++) begin
      if (i <= int'(ptr)) dbl[i] = 1'b0;
    end
    gnt_idx = '0;
    // Scan downwards so the lowest set position is the one left standing.
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) gnt_idx = (i >= N) ? IW'(i - N) : IW'(i);
    end
    gnt = N'(|req) << gnt_idx;
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// rtl/sb_tx_arbiter.sv - packet-atomic round-robin arbiter onto one TX sink
//
// Purpose: share one switchboard TX sink among N requesters. A winner owns
// the sink until it transfers a beat with last=1. The output is a single
// registered slice; in_ready depends combinationally on out_ready (no skid
// buffer), which integrators must account for in timing.
// Ports:
//   clk       in  1     clock
//   nreset    in  1     asynchronous active-low reset
//   in_data   in  N*DW  requester data, port i at [i*DW +: DW]
//   in_dest   in  N*32  requester destination, port i at [i*32 +: 32]
//   in_last   in  N     end-of-packet flag per requester
//   in_valid  in  N     per-requester valid
//   in_ready  out N     per-requester ready
//   out_data  out DW    registered data
//   out_dest  out 32    registered destination
//   out_last  out 1     registered last
//   out_valid out 1     registered valid
//   out_ready in  1     sink ready
//   locked    out 1     a packet is in progress
//   owner     out IW    current or last-granted requester

module sb_tx_arbiter import sb_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int DW = 416,
  localparam int IW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N*DW-1:0] in_data,
  input  logic [N*32-1:0] in_dest,
  input  logic [N-1:0]    in_last,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [DW-1:0]   out_data,
  output logic [31:0]     out_dest,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            locked,
  output logic [IW-1:0]   owner
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;

  logic          space;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel;
  logic [DW-1:0] sel_data;
  logic [31:0]   sel_dest;
  logic          sel_last;
  logic          in_xfer;

  sb_rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // The slice can take a beat when empty or when its beat leaves this cycle.
  assign space = !out_valid || out_ready;
  assign sel   = (state_q == ST_LOCKED) ? owner_q : pick_idx;

  always_comb begin
    sel_data = '0;
    sel_dest = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        sel_data = in_data[i*DW +: DW];
        sel_dest = in_dest[i*32 +: 32];
        sel_last = in_last[i];
      end
    end
  end

  // While locked the owner sees ready even without valid; others never do.
  // Ready is forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (nreset) begin
      if (state_q == ST_LOCKED) in_ready = N'(space) << owner_q;
      else                      in_ready = pick_gnt & {N{space}};
    end
  end

  assign in_xfer = |(in_ready & in_valid);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (in_xfer) begin
      if (state_q == ST_UNLOCKED) begin
        ptr_d   = pick_idx;
        owner_d = pick_idx;
        if (!sel_last) state_d = ST_LOCKED;
      end else if (sel_last) begin
        // ptr already equals owner, so the next scan starts at owner+1.
        state_d = ST_UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_UNLOCKED;
      ptr_q   <= IW'(N-1);
      owner_q <= IW'(N-1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_last  <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_dest  <= sel_dest;
      out_last  <= sel_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign locked = (state_q == ST_LOCKED);
  assign owner  = owner_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// tb/tb_sb_tx_arbiter.sv - self-checking bench for sb_tx_arbiter

module tb_sb_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int BW = DW + 33;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N*32-1:0] in_dest = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic [31:0]     out_dest;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            locked;
  logic [IW-1:0]   owner;

  always #5 clk = ~clk;

  sb_tx_arbiter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .owner     (owner)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: arbiter state kept as plain integers.
  int            m_ptr, m_owner;
  bit            m_locked, m_ov, m_ol;
  logic [DW-1:0] m_od;
  logic [31:0]   m_odest;

  // Requester beat queues {last, dest, data}, per-port idle request, handshakes.
  logic [BW-1:0] q[N][$];
  bit            gap[N];
  logic [N-1:0]  hs;
  logic [BW-1:0] out_log[$];
  int            pushed;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input bit last, input logic [31:0] dest, input logic [DW-1:0] data);
    return {last, dest, data};
  endfunction

  task automatic chk_log(input string nm, input int idx, input logic [BW-1:0] exp);
    logic [127:0] a;
    a = 'x;
    if (idx < out_log.size()) a = 128'(out_log[idx]);
    chk(nm, a, 128'(exp));
  endtask

  task automatic chk_log_dest(input string nm, input int idx, input logic [31:0] exp);
    logic [127:0] a;
    a = 'x;
    if (idx < out_log.size()) a = 128'(out_log[idx][DW+31:DW]);
    chk(nm, a, 128'(exp));
  endtask

  // Compare DUT against the model for this cycle, then advance the model.
  task automatic model_step();
    bit           space;
    int           sel;
    logic [N-1:0] er;
    space = !m_ov || out_ready;
    sel = -1;
    if (m_locked) sel = m_owner;
    else begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (sel < 0 && in_valid[p]) sel = p;
      end
    end
    er = '0;
    if (sel >= 0 && space) er[sel] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_dest", out_dest, m_odest);
      chk("out_last", out_last, m_ol);
    end
    chk("locked", locked, m_locked);
    chk("owner", owner, m_owner);
    hs = in_valid & in_ready;
    if (sel >= 0 && er[sel] && in_valid[sel]) begin
      m_od    = in_data[sel*DW +: DW];
      m_odest = in_dest[sel*32 +: 32];
      m_ol    = in_last[sel];
      m_ov    = 1'b1;
      if (!m_locked) begin
        m_ptr    = sel;
        m_owner  = sel;
        m_locked = !in_last[sel];
      end else if (in_last[sel]) begin
        m_locked = 1'b0;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic drive();
    logic [BW-1:0] b;
    for (int p = 0; p < N; p++) begin
      if (q[p].size() > 0 && !gap[p]) begin
        b = q[p][0];
        in_data[p*DW +: DW] = b[DW-1:0];
        in_dest[p*32 +: 32] = b[DW+31:DW];
        in_last[p]          = b[BW-1];
        in_valid[p]         = 1'b1;
      end else begin
        in_valid[p] = 1'b0;
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_step();
    if (out_valid && out_ready) out_log.push_back({out_last, out_dest, out_data});
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) if (hs[p]) void'(q[p].pop_front());
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      step();
      done = all_empty() && !out_valid;
    end
    chk(nm, done, 1'b1);
  endtask

  // Assert reset now (asynchronously), check reset outputs, release on next edge.
  task automatic reset_body();
    in_valid = '1;
    nreset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_locked", locked, 0);
    chk("rst_owner", owner, N-1);
    in_valid = '0;
    m_ptr = N-1; m_owner = N-1; m_locked = 1'b0; m_ov = 1'b0;
    m_od = '0; m_odest = '0; m_ol = 1'b0;
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      gap[p] = 1'b0;
    end
    out_log.delete();
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_body();
  endtask

  initial begin
    hs = '0;
    pushed = 0;
    for (int p = 0; p < N; p++) gap[p] = 1'b0;

    // Single requester, 3-beat packet from port 2.
    do_reset();
    out_ready = 1'b1;
    q[2].push_back(mk(0, 32'h10, 64'hA0));
    q[2].push_back(mk(0, 32'h10, 64'hA1));
    q[2].push_back(mk(1, 32'h10, 64'hA2));
    step();
    chk("t1_locked_b1", locked, 1);
    chk("t1_owner", owner, 2);
    step();
    step();
    chk("t1_locked_end", locked, 0);
    chk("t1_last", out_last, 1);
    drain("t1_drain");
    chk("t1_count", out_log.size(), 3);
    chk_log("t1_b0", 0, mk(0, 32'h10, 64'hA0));
    chk_log("t1_b1", 1, mk(0, 32'h10, 64'hA1));
    chk_log("t1_b2", 2, mk(1, 32'h10, 64'hA2));

    // Round-robin fairness with single-beat packets on every port.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      for (int p = 0; p < N; p++)
        if (q[p].size() == 0) q[p].push_back(mk(1, 32'(p), 64'(c)));
      step();
    end
    for (int k = 0; k < 8; k++) chk_log_dest("t2_order", k, 32'(k % 4));

    // Packet atomicity: port 0 4-beat packet while port 1 waits.
    do_reset();
    for (int b = 0; b < 4; b++) q[0].push_back(mk(b == 3, 32'h100, 64'(b)));
    q[1].push_back(mk(1, 32'h101, 64'h55));
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t3_rdy1", in_ready[1], 0);
      step();
    end
    drain("t3_drain");
    chk("t3_count", out_log.size(), 5);
    for (int k = 0; k < 4; k++) chk_log_dest("t3_dest0", k, 32'h100);
    chk_log("t3_p1", 4, mk(1, 32'h101, 64'h55));

    // Backpressure mid-packet.
    do_reset();
    for (int b = 0; b < 4; b++) q[1].push_back(mk(b == 3, 32'h200, 64'hB0 + 64'(b)));
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_rdy", in_ready, 0);
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 64'hB1);
    end
    out_ready = 1'b1;
    drain("t4_drain");
    chk("t4_count", out_log.size(), 4);
    for (int k = 0; k < 4; k++) chk_log("t4_beat", k, mk(k == 3, 32'h200, 64'hB0 + 64'(k)));

    // Owner stall: port 0 drops valid mid-packet while port 3 waits.
    do_reset();
    for (int b = 0; b < 4; b++) q[0].push_back(mk(b == 3, 32'h300, 64'hC0 + 64'(b)));
    q[3].push_back(mk(1, 32'h303, 64'hCC));
    step();
    gap[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_rdy3", in_ready[3], 0);
      chk("t5_locked", locked, 1);
    end
    gap[0] = 1'b0;
    drain("t5_drain");
    chk("t5_count", out_log.size(), 5);
    for (int k = 0; k < 4; k++) chk_log_dest("t5_dest0", k, 32'h300);
    chk_log_dest("t5_p3", 4, 32'h303);

    // Asynchronous reset during beat 2.
    do_reset();
    for (int b = 0; b < 4; b++) q[1].push_back(mk(b == 3, 32'h350, 64'hD0 + 64'(b)));
    step();
    drive();
    chk("t6_pre_locked", locked, 1);
    chk("t6_pre_valid", out_valid, 1);
    #3;
    reset_body();
    for (int p = 0; p < 3; p++) q[p].push_back(mk(1, 32'h400 + 32'(p), 64'(p)));
    drive();
    #1;
    chk("t6_first_grant", in_ready, 4'b0001);
    drain("t6_drain");
    chk_log_dest("t6_first", 0, 32'h400);

    // Randomized traffic with backpressure and idle gaps.
    out_log.delete();
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (q[p].size() < 2 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            q[p].push_back(mk(b == len-1, (32'(p) << 16) | 32'(c), {$urandom(), $urandom()}));
          pushed += len;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < N; p++)
        gap[p] = (in_valid[p] && !hs[p]) ? 1'b0 : ($urandom_range(0, 4) == 0);
      step();
    end
    out_ready = 1'b1;
    for (int p = 0; p < N; p++) gap[p] = 1'b0;
    drain("rand_drain");
    chk("rand_beats", out_log.size(), pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
